// File: rtl/stack_arbiter_if.sv
// Client-side bundle of the stack arbiter: two request ports plus shared result/occupancy.
// Handshake: a client raises REQx with CMDx/IDXx/WDATAx and holds them stable until ACKx
// pulses for one cycle; ERRx qualifies that ACK, RDATA is valid with it, and REQx still
// high in the cycle after ACKx is a new request.
interface stack_arbiter_if #(
  parameter int DW = 4,
  parameter int IW = 3,
  parameter int CW = 3
);
  logic          REQ0, REQ1;
  logic [1:0]    CMD0, CMD1;
  logic [IW-1:0] IDX0, IDX1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          ACK0, ACK1;
  logic          ERR0, ERR1;
  logic [DW-1:0] RDATA;
  logic [CW-1:0] COUNT;

  modport master (
    output REQ0, REQ1, CMD0, CMD1, IDX0, IDX1, WDATA0, WDATA1,
    input  ACK0, ACK1, ERR0, ERR1, RDATA, COUNT
  );

  modport slave (
    input  REQ0, REQ1, CMD0, CMD1, IDX0, IDX1, WDATA0, WDATA1,
    output ACK0, ACK1, ERR0, ERR1, RDATA, COUNT
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin two-port front end for a shared stack: checks legality against a local
// occupancy count, issues one stack command at a time and returns POP/GET data.
module stack_arbiter #(
  parameter int  DEPTH = 5,
  parameter int  DW    = 4,
  parameter int  IW    = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           CLK,
  input  logic           RESET,
  stack_arbiter_if.slave bus,
  output logic           ST_RESET,
  output logic [1:0]     ST_COMMAND,
  output logic [IW-1:0]  ST_INDEX,
  inout  wire  [DW-1:0]  ST_DATA,
  output logic [1:0]     dbg_state,
  output logic           dbg_drive
);
  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_PUSH = 2'b01;
  localparam logic [1:0] C_POP  = 2'b10;
  localparam logic [1:0] C_GET  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count;
  logic [1:0]    ack_q, err_q, rst_q;
  logic [DW-1:0] rdata_q, wdata_q;
  logic [1:0]    cmd_q;
  logic [IW-1:0] idx_q;
  logic          port_q, rr_ptr;
  logic          elig0, elig1, grant, win, legal, issue;
  logic [1:0]    w_cmd;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_wdata;

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    legal   = 1'b1;
    // A port whose ACK is high this cycle is finishing, so only the other port may win.
    elig0   = bus.REQ0 & ~ack_q[0] & ~rst_q[1];
    elig1   = bus.REQ1 & ~ack_q[1] & ~rst_q[1];
    win     = (elig0 & elig1) ? rr_ptr : elig1;
    grant   = (state == IDLE) & (elig0 | elig1);
    w_cmd   = win ? bus.CMD1   : bus.CMD0;
    w_idx   = win ? bus.IDX1   : bus.IDX0;
    w_wdata = win ? bus.WDATA1 : bus.WDATA0;
    case (w_cmd)
      C_PUSH:  legal = (count != CW'(DEPTH));
      C_POP:   legal = (count != '0);
      C_GET:   legal = (int'(w_idx) < int'(count));
      default: legal = 1'b1;
    endcase
    case (state)
      IDLE: begin
        if (grant && legal && (w_cmd != C_NOP)) begin
          issue   = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC:    state_n = (cmd_q == C_PUSH) ? IDLE : RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rst_q   <= 2'b11;
      rdata_q <= '0;
      wdata_q <= '0;
      cmd_q   <= C_NOP;
      idx_q   <= '0;
      port_q  <= 1'b0;
      rr_ptr  <= 1'b0;
    end else begin
      // Two stages keep ST_RESET high through one full cycle after release.
      rst_q <= {rst_q[0], 1'b0};
      ack_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            rr_ptr  <= ~win;
            port_q  <= win;
            cmd_q   <= w_cmd;
            idx_q   <= w_idx;
            wdata_q <= w_wdata;
            if (!issue) begin
              ack_q[win] <= 1'b1;
              err_q[win] <= ~legal;
            end
          end
        end
        EXEC: begin
          if (cmd_q == C_PUSH) begin
            count         <= count + CW'(1);
            ack_q[port_q] <= 1'b1;
          end else if (cmd_q == C_POP) begin
            count <= count - CW'(1);
          end
        end
        RESP: begin
          rdata_q       <= ST_DATA;
          ack_q[port_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_drive  = (state == EXEC) && (cmd_q == C_PUSH);
  assign dbg_state  = state;
  assign ST_RESET   = rst_q[1];
  assign ST_COMMAND = (state == EXEC) ? cmd_q : C_NOP;
  assign ST_INDEX   = (state == EXEC) ? idx_q : '0;
  assign ST_DATA    = dbg_drive ? wdata_q : {DW{1'bz}};

  assign bus.ACK0  = ack_q[0];
  assign bus.ACK1  = ack_q[1];
  assign bus.ERR0  = err_q[0];
  assign bus.ERR1  = err_q[1];
  assign bus.RDATA = rdata_q;
  assign bus.COUNT = count;
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural stack on the ST_* side, per-port expected queues
// filled from a reference stack model when requests are driven, drained on each ACK.
module tb_stack_arbiter;
  localparam int DEPTH = 5;
  localparam int DW    = 4;
  localparam int IW    = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = 2 + 1 + DW + CW;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] GET  = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_arbiter_if #(.DW(DW), .IW(IW), .CW(CW)) bus ();

  logic          st_reset;
  logic [1:0]    st_command;
  logic [IW-1:0] st_index;
  wire  [DW-1:0] st_data;
  logic [1:0]    dbg_state;
  logic          dbg_drive;

  stack_arbiter #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .bus        (bus),
    .ST_RESET   (st_reset),
    .ST_COMMAND (st_command),
    .ST_INDEX   (st_index),
    .ST_DATA    (st_data),
    .dbg_state  (dbg_state),
    .dbg_drive  (dbg_drive)
  );

  // behavioural stack: registered read data driven in the cycle after POP/GET
  logic [DW-1:0] stk_mem [DEPTH];
  int            stk_sp = 0;
  logic          stk_oe = 1'b0;
  logic [DW-1:0] stk_out = '0;
  assign st_data = stk_oe ? stk_out : {DW{1'bz}};

  always @(posedge clk) begin
    stk_oe <= 1'b0;
    if (st_reset) begin
      stk_sp <= 0;
    end else begin
      case (st_command)
        PUSH: if (stk_sp < DEPTH) begin
          stk_mem[stk_sp] <= st_data;
          stk_sp <= stk_sp + 1;
        end
        POP: if (stk_sp > 0) begin
          stk_out <= stk_mem[stk_sp-1];
          stk_oe  <= 1'b1;
          stk_sp  <= stk_sp - 1;
        end
        GET: if (int'(st_index) < stk_sp) begin
          stk_out <= stk_mem[stk_sp-1-int'(st_index)];
          stk_oe  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;
  int drv_cyc [2];
  bit chk_lat = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: entry = {latency, err, rdata, count}; latency 0 means not checked
  logic [DW-1:0] m_stk [$];
  logic [DW-1:0] m_rd = '0;
  logic [EW-1:0] exp_q0 [$];
  logic [EW-1:0] exp_q1 [$];

  task automatic expect_op(input int port, input logic [1:0] cmd, input int idx,
                           input logic [DW-1:0] wd, output bit quiet);
    logic       err;
    logic [1:0] lat;
    logic [EW-1:0] e;
    err = 1'b0;
    lat = 2'd1;
    case (cmd)
      PUSH: if (m_stk.size() == DEPTH) err = 1'b1;
            else begin m_stk.push_back(wd); lat = 2'd2; end
      POP:  if (m_stk.size() == 0) err = 1'b1;
            else begin m_rd = m_stk.pop_back(); lat = 2'd3; end
      GET:  if (idx >= m_stk.size()) err = 1'b1;
            else begin m_rd = m_stk[m_stk.size()-1-idx]; lat = 2'd3; end
      default: ;
    endcase
    quiet = (lat == 2'd1);
    if (!chk_lat) lat = 2'd0;
    e = {lat, err, m_rd, CW'(m_stk.size())};
    if (port == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
  endtask

  task automatic sb_pop(input int port);
    logic [EW-1:0] e;
    logic [1:0]    lat;
    logic          err;
    logic [DW-1:0] rd;
    logic [CW-1:0] cnt;
    if (port == 0 && exp_q0.size() == 0) begin
      check("p0_unexpected_ack_qsize", exp_q0.size(), 1);
      return;
    end
    if (port == 1 && exp_q1.size() == 0) begin
      check("p1_unexpected_ack_qsize", exp_q1.size(), 1);
      return;
    end
    e = (port == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    {lat, err, rd, cnt} = e;
    check($sformatf("p%0d_err", port), (port == 0) ? bus.ERR0 : bus.ERR1, err);
    check($sformatf("p%0d_rdata", port), bus.RDATA, rd);
    check($sformatf("p%0d_count", port), bus.COUNT, cnt);
    if (lat != 2'd0) check($sformatf("p%0d_latency", port), cyc - drv_cyc[port], lat);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ACK0) sb_pop(0);
      if (bus.ACK1) sb_pop(1);
      check("bus_oe_only_push", dbg_drive, st_command == PUSH);
    end
  end

  // driver tasks
  task automatic drive(input int port, input logic [1:0] cmd, input int idx,
                       input logic [DW-1:0] wd, input bit do_exp);
    bit quiet;
    bit got;
    quiet = 1'b0;
    if (do_exp) expect_op(port, cmd, idx, wd, quiet);
    @(posedge clk);
    #1;
    drv_cyc[port] = cyc;
    if (port == 0) begin
      bus.REQ0 = 1'b1; bus.CMD0 = cmd; bus.IDX0 = IW'(idx); bus.WDATA0 = wd;
    end else begin
      bus.REQ1 = 1'b1; bus.CMD1 = cmd; bus.IDX1 = IW'(idx); bus.WDATA1 = wd;
    end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (quiet) check($sformatf("p%0d_no_stack_cmd", port), st_command, NOP);
      got = (port == 0) ? bus.ACK0 : bus.ACK1;
    end
    if (!got) check($sformatf("p%0d_ack_timeout", port), got, 1'b1);
    if (port == 0) bus.REQ0 = 1'b0;
    else           bus.REQ1 = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    m_stk.delete();
    m_rd = '0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", bus.COUNT, 0);
    check("rst_ack", {bus.ACK1, bus.ACK0}, 0);
    check("rst_err", {bus.ERR1, bus.ERR0}, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_st_cmd", st_command, NOP);
    check("rst_st_index", st_index, 0);
    check("rst_st_reset", st_reset, 1);
    check("rst_bus_oe", dbg_drive, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk) check("rel_st_reset_a", st_reset, 1);
    @(negedge clk) check("rel_st_reset_b", st_reset, 1);
    @(negedge clk) check("rel_st_reset_c", st_reset, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.REQ0 = 0; bus.CMD0 = NOP; bus.IDX0 = '0; bus.WDATA0 = '0;
    bus.REQ1 = 0; bus.CMD1 = NOP; bus.IDX1 = '0; bus.WDATA1 = '0;
    reset_dut();

    // fill, overflow, NOP, GET sweep, drain, underflow
    for (int v = 1; v <= 5; v++) drive(0, PUSH, 0, DW'(v), 1'b1);
    drive(0, PUSH, 0, 4'h6, 1'b1);
    drive(0, NOP, 0, 4'h0, 1'b1);
    for (int i = 0; i <= 5; i++) drive(0, GET, i, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) drive(0, POP, 0, 4'h0, 1'b1);
    drive(1, PUSH, 0, 4'h9, 1'b1);
    drive(1, GET, 1, 4'h0, 1'b1);
    drive(1, POP, 0, 4'h0, 1'b1);

    // random single-port mix
    for (int i = 0; i < 20; i++)
      drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 6),
            DW'($urandom_range(0, 15)), 1'b1);

    // reset during POP EXEC
    reset_dut();
    drive(0, PUSH, 0, 4'h7, 1'b1);
    @(posedge clk);
    #1;
    bus.REQ0 = 1'b1; bus.CMD0 = POP;
    @(posedge clk);
    #1;
    check("midop_state_exec", dbg_state, 1);
    check("midop_cmd_pop", st_command, POP);
    rst_n = 1'b0;
    #1;
    check("abort_cmd", st_command, NOP);
    check("abort_oe", dbg_drive, 0);
    check("abort_count", bus.COUNT, 0);
    check("abort_st_reset", st_reset, 1);
    check("abort_ack", bus.ACK0, 0);
    bus.REQ0 = 1'b0; bus.CMD0 = NOP;
    reset_dut();
    drive(0, POP, 0, 4'h0, 1'b1);

    // contention: both ports push from reset, grants must alternate 0,1,0,1
    reset_dut();
    chk_lat = 1'b0;
    begin
      bit q;
      expect_op(0, PUSH, 0, 4'hA, q);
      expect_op(1, PUSH, 0, 4'h5, q);
      expect_op(0, PUSH, 0, 4'hA, q);
      expect_op(1, PUSH, 0, 4'h5, q);
    end
    fork
      begin
        drive(0, PUSH, 0, 4'hA, 1'b0);
        drive(0, PUSH, 0, 4'hA, 1'b0);
      end
      begin
        drive(1, PUSH, 0, 4'h5, 1'b0);
        drive(1, PUSH, 0, 4'h5, 1'b0);
      end
    join
    chk_lat = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, GET, i, 4'h0, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_left_p0", exp_q0.size(), 0);
    check("sb_left_p1", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Two-requester front end for the shared stack_behaviour_normal instance. The stack instance uses COMMAND NOP=00, PUSH=01, POP=10, GET=11 and a bidirectional O_DATA bus.
- Arbitrates round-robin and tracks occupancy. Rejects illegal operations before they reach the stack.
- Sequences one stack command at a time and returns POP/GET data to the winning requester.
- Sits between the stack and its client logic; clients never drive the stack directly.

Parameters:
- DEPTH, 5, stack capacity in entries.
- DW, 4, data width.
- IW, 3, GET index width.
- CW, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0, REQ1  in  1  request from port 0 / port 1.
- CMD0, CMD1  in  2  requested command (NOP, PUSH, POP, GET encoding).
- IDX0, IDX1  in  IW  GET index; 0 = top of stack.
- WDATA0, WDATA1  in  DW  PUSH data.
- ACK0, ACK1  out  1  one-cycle completion pulse.
- ERR0, ERR1  out  1  qualifies ACK: the operation was rejected.
- RDATA  out  DW  POP/GET result; valid while the matching ACK is high.
- COUNT  out  CW  current occupancy.
- ST_RESET  out  1  active-high synchronous reset to the stack.
- ST_COMMAND  out  2  stack command.
- ST_INDEX  out  IW  stack index.
- ST_DATA  inout  DW  stack data bus; driven by this block only during PUSH EXEC, Z otherwise.

Behaviour:
- Reset (RESET low, async):
  - State=IDLE, COUNT=0, ACK*=0, ERR*=0, RDATA=0.
  - ST_COMMAND=NOP, ST_INDEX=0, ST_DATA=Z, round-robin pointer=port 0, ST_RESET=1.
- Reset release: ST_RESET stays 1 for the first full clock cycle after RESET rises, then 0. No grant occurs in that cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Eligible port: REQ=1 and its ACK not high in this cycle.
  - If both are eligible, grant the port the pointer names. The pointer moves to the other port after each grant, including rejected grants.
  - On the granting edge, latch CMD/IDX/WDATA of the winner.
- Legality check (evaluated in IDLE on the winner's live inputs):
  - PUSH with COUNT==DEPTH is illegal.
  - POP with COUNT==0 is illegal.
  - GET with IDX>=COUNT is illegal.
  - NOP is legal but is never issued to the stack.
- Illegal operation or NOP: the next cycle has ACKx=1; ERRx=1 for illegal, ERRx=0 for NOP. State stays IDLE and the stack sees no command.
- Legal PUSH/POP/GET: IDLE->EXEC.
- EXEC (1 cycle):
  - ST_COMMAND=latched CMD, ST_INDEX=latched IDX.
  - For PUSH, ST_DATA=latched WDATA. For POP/GET, ST_DATA=Z.
  - At the end edge: PUSH increments COUNT, POP decrements it.
  - PUSH: EXEC->IDLE, and the next cycle has ACKx=1, ERRx=0.
  - POP/GET: EXEC->RESP.
- RESP (1 cycle): ST_COMMAND=NOP, ST_DATA=Z. At the end edge RDATA<=ST_DATA and ACKx<=1. RESP->IDLE.
- Latency, counting cycles from the IDLE cycle in which REQ is sampled:
  - Reject or NOP: ACK at +1.
  - PUSH: ACK at +2.
  - POP/GET: ACK at +3.
- Throughput: at most one operation in flight. A new grant can occur in the same cycle an ACK is high, but only to the other port.
- Handshake:
  - The requester holds REQ/CMD/IDX/WDATA stable until it sees ACK.
  - A REQ that stays high in the cycle after ACK is treated as a new request.
  - Dropping REQ before grant withdraws the request. Dropping REQ after grant has no effect.
- RDATA holds its last captured value between POP/GET completions. It is not updated by PUSH or rejects.
- Bus contention: ST_DATA must be Z in every cycle except PUSH EXEC. This includes reset and the cycle right after RESET release.
- Reset mid-operation: abort immediately, with no ACK for the aborted operation. COUNT=0 and the stack is cleared via ST_RESET.

Test Plan:
- Reset then single port: RESET low 2 cycles, then high; port 0 PUSHes 1,2,3,4,5 back-to-back → each ACK0 2 cycles after its grant, ERR0=0, COUNT 1..5. A 6th PUSH → ACK0 with ERR0=1 and COUNT stays 5.
- GET sweep: with stack [top]5,4,3,2,1, GET IDX=0..4 → RDATA 5,4,3,2,1, each 3 cycles after its request. GET IDX=5 → ERR0=1 at +1, and ST_COMMAND is never 11 for it.
- POP to empty: 5 POPs → RDATA 5,4,3,2,1, COUNT 4..0. A 6th POP → ERR0=1, no stack command issued.
- Contention: REQ0 and REQ1 both held with PUSH, WDATA0=A, WDATA1=B, from reset → grants alternate 0,1,0,1. Stack contents interleave A,B,A,B, and no port is granted twice consecutively while the other waits.
- Reset mid-op: drop RESET during EXEC of a POP → ST_COMMAND=NOP and ST_DATA=Z immediately, no ACK, COUNT=0. ST_RESET=1 through the first cycle after release, and a following POP returns ERR.
- Bus check: in every cycle, ST_DATA is driven only when ST_COMMAND==PUSH.
